// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Desc     : Time-multiplexed 7-segment scanner with double-buffered display
//            data, frame-aligned load handshake and a blanking guard at the
//            start of every digit slot. Define SEG7_DIM_EN for BRIGHT dimming.
// Revision : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_CYCLES   = 8192,
    parameter int BLANK_CYCLES   = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit CS_ACTIVE_LOW  = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] HEX_IN,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic [NUM_DIGITS-1:0]   DIG_EN,
    input  logic                    LOAD,
`ifdef SEG7_DIM_EN
    input  logic [3:0]              BRIGHT,
`endif
    output logic [7:0]              SEG,
    output logic [NUM_DIGITS-1:0]   SEG7_CS,
    output logic                    FRAME_SYNC,
    output logic                    LOAD_ACK
);

    localparam int c_SLOT_W = $clog2(DIGIT_CYCLES);
    localparam int c_IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_LEN_W  = c_SLOT_W + 5;
    localparam logic [7:0]            c_SEG_OFF = {8{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] c_CS_OFF  = {NUM_DIGITS{CS_ACTIVE_LOW}};

    logic [c_SLOT_W-1:0]     r_slot_cnt;
    logic [c_IDX_W-1:0]      r_digit_idx;
    logic [4*NUM_DIGITS-1:0] r_sh_hex, r_act_hex;
    logic [NUM_DIGITS-1:0]   r_sh_dp, r_act_dp;
    logic [NUM_DIGITS-1:0]   r_sh_en, r_act_en;
    logic                    r_pending;

    logic                    w_slot_wrap;
    logic                    w_frame_start;
    logic                    w_lit_win;
    logic                    w_on;
    logic [3:0]              w_nib;
    logic [7:0]              w_seg_hi;
    logic [NUM_DIGITS-1:0]   w_cs_hi;

    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        case (nib)
            4'h0:    decode_hex = 7'h3F;
            4'h1:    decode_hex = 7'h06;
            4'h2:    decode_hex = 7'h5B;
            4'h3:    decode_hex = 7'h4F;
            4'h4:    decode_hex = 7'h66;
            4'h5:    decode_hex = 7'h6D;
            4'h6:    decode_hex = 7'h7D;
            4'h7:    decode_hex = 7'h07;
            4'h8:    decode_hex = 7'h7F;
            4'h9:    decode_hex = 7'h6F;
            4'hA:    decode_hex = 7'h77;
            4'hB:    decode_hex = 7'h7C;
            4'hC:    decode_hex = 7'h39;
            4'hD:    decode_hex = 7'h5E;
            4'hE:    decode_hex = 7'h79;
            default: decode_hex = 7'h71;
        endcase
    endfunction

    assign w_slot_wrap   = (r_slot_cnt == c_SLOT_W'(DIGIT_CYCLES - 1));
    assign w_frame_start = (r_slot_cnt == '0) && (r_digit_idx == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= '0;
        end else if (w_slot_wrap) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= (r_digit_idx == c_IDX_W'(NUM_DIGITS - 1)) ?
                           '0 : r_digit_idx + c_IDX_W'(1);
        end else begin
            r_slot_cnt  <= r_slot_cnt + c_SLOT_W'(1);
        end
    end

    // A LOAD coinciding with the frame boundary bypasses the shadow copy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sh_hex  <= '0;
            r_sh_dp   <= '0;
            r_sh_en   <= '0;
            r_act_hex <= '0;
            r_act_dp  <= '0;
            r_act_en  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (LOAD) begin
                r_sh_hex <= HEX_IN;
                r_sh_dp  <= DP_IN;
                r_sh_en  <= DIG_EN;
            end
            if (w_frame_start) begin
                if (LOAD) begin
                    r_act_hex <= HEX_IN;
                    r_act_dp  <= DP_IN;
                    r_act_en  <= DIG_EN;
                end else if (r_pending) begin
                    r_act_hex <= r_sh_hex;
                    r_act_dp  <= r_sh_dp;
                    r_act_en  <= r_sh_en;
                end
                r_pending <= 1'b0;
            end else if (LOAD) begin
                r_pending <= 1'b1;
            end
        end
    end

`ifdef SEG7_DIM_EN
    logic [c_LEN_W-1:0] r_lit_len;
    logic [c_LEN_W-1:0] w_lit_prod;

    assign w_lit_prod = (c_LEN_W'(BRIGHT) + c_LEN_W'(1)) *
                        c_LEN_W'(DIGIT_CYCLES - BLANK_CYCLES);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lit_len <= c_LEN_W'(DIGIT_CYCLES - BLANK_CYCLES);
        end else if (w_frame_start) begin
            r_lit_len <= w_lit_prod >> 4;
        end
    end

    assign w_lit_win = (c_LEN_W'(r_slot_cnt) - c_LEN_W'(BLANK_CYCLES)) < r_lit_len;
`else
    assign w_lit_win = 1'b1;
`endif

    assign w_nib    = r_act_hex[{r_digit_idx, 2'b00} +: 4];
    assign w_on     = (r_slot_cnt >= c_SLOT_W'(BLANK_CYCLES)) && w_lit_win &&
                      r_act_en[r_digit_idx];
    assign w_seg_hi = w_on ? {r_act_dp[r_digit_idx], decode_hex(w_nib)} : 8'h00;

    always_comb begin
        w_cs_hi = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_cs_hi[i] = w_on && (r_digit_idx == c_IDX_W'(i));
        end
    end

    // XOR with the off pattern converts active-high form to pin polarity.
    always_ff @(posedge CLK) begin
        if (RST) begin
            SEG        <= c_SEG_OFF;
            SEG7_CS    <= c_CS_OFF;
            FRAME_SYNC <= 1'b0;
            LOAD_ACK   <= 1'b0;
        end else begin
            SEG        <= w_seg_hi ^ c_SEG_OFF;
            SEG7_CS    <= w_cs_hi ^ c_CS_OFF;
            FRAME_SYNC <= w_frame_start;
            LOAD_ACK   <= w_frame_start && (LOAD || r_pending);
        end
    end

endmodule
`default_nettype wire
